// File: rtl/rc_responder.sv
// rtl/rc_responder.sv - iterative MUL/MULHU/POPC responder with a four-phase cmd/done handshake
module rc_responder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rc_cmd,
  input  logic [DATA_W-1:0] rc_op1,
  input  logic [DATA_W-1:0] rc_op2,
  input  logic [1:0]        rc_fun,
  output logic              rc_done,
  output logic [DATA_W-1:0] rc_result,
  output logic              rc_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mplr_q, mplr_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [1:0]          fun_q, fun_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic [DATA_W:0]     sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      mcand_q  <= '0;
      fun_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      mcand_q  <= mcand_d;
      fun_q    <= fun_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    mcand_d  = mcand_q;
    fun_d    = fun_q;
    result_d = result_q;
    done_d   = 1'b0;
    sum      = '0;
    case (state_q)
      IDLE: begin
        if (rc_cmd) begin
          mplr_d  = rc_op1;
          mcand_d = rc_op2;
          fun_d   = rc_fun;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!rc_cmd) begin
          state_d = IDLE;
        end else if (cnt_q != ITERS) begin
          // Right-shifting shift-add: high half accumulates, product settles into acc after DATA_W steps.
          case (fun_q)
            2'b00, 2'b01: begin
              sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
              acc_d = {sum, acc_q[DATA_W-1:1]};
            end
            2'b10:   acc_d = acc_q + {{(2*DATA_W-1){1'b0}}, mplr_q[0]};
            default: acc_d = acc_q;
          endcase
          mplr_d = mplr_q >> 1;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          case (fun_q)
            2'b00:   result_d = acc_q[DATA_W-1:0];
            2'b01:   result_d = acc_q[2*DATA_W-1:DATA_W];
            2'b10:   result_d = acc_q[DATA_W-1:0];
            default: result_d = '0;
          endcase
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: if (!rc_cmd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rc_done   = done_q;
  assign rc_result = result_q;
  assign rc_busy   = (state_q != IDLE);

endmodule

// File: doc/rc_responder.md
RC_RESPONDER -- requirements
Module: rc_responder

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; iteration count equals DATA_W.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rc_cmd  input  1  level request from control path; held high until rc_done is seen.
REQ-005 rc_op1  input  DATA_W  operand 1 (rs1 value), sampled only at accept.
REQ-006 rc_op2  input  DATA_W  operand 2 (rs2/immediate), sampled only at accept.
REQ-007 rc_fun  input  2  function select, sampled only at accept.
REQ-008 rc_done  output  1  one-cycle completion pulse, registered.
REQ-009 rc_result  output  DATA_W  result for RC writeback, registered.
REQ-010 rc_busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement states IDLE, RUN, DONE, RELEASE.
REQ-012 IDLE: rc_cmd=1 at an edge SHALL capture rc_op1, rc_op2, rc_fun, clear the accumulator and the iteration counter, and move to RUN.
REQ-013 RUN SHALL perform one iteration per cycle for exactly DATA_W cycles, counter 0..DATA_W-1, then move to DONE.
REQ-014 rc_fun=00 (MUL) SHALL produce the low DATA_W bits of the unsigned op1*op2 product via shift-add, one multiplier bit per iteration, with a 2*DATA_W-bit accumulator.
REQ-015 rc_fun=01 (MULHU) SHALL produce the high DATA_W bits of the same unsigned product.
REQ-016 rc_fun=10 (POPC) SHALL produce the count of set bits in op1, one bit per iteration, zero-extended to DATA_W; op2 is ignored.
REQ-017 rc_fun=11 (reserved) SHALL run the full DATA_W iterations and produce result 0.
REQ-018 Latency: accept at edge k; rc_done SHALL be high during exactly the cycle after edge k+DATA_W+1 (DONE state), with rc_result valid in that cycle.
REQ-019 DONE SHALL last exactly one cycle and always move to RELEASE.
REQ-020 RELEASE SHALL move to IDLE at the first edge where rc_cmd=0; while rc_cmd=1 it SHALL remain in RELEASE, so one rc_cmd assertion yields exactly one operation.
REQ-021 rc_result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during RUN.
REQ-022 rc_cmd=0 sampled in RUN (abort) SHALL return to IDLE at that edge, without rc_done and without changing rc_result.
REQ-023 Operand or rc_fun changes after accept SHALL have no effect on the current operation.
REQ-024 Minimum spacing: with rc_cmd low for one cycle after done, a new request SHALL be accepted at the following edge.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, rc_done=0, rc_busy=0, rc_result=0, and clear the counter and accumulator, including in the middle of RUN or DONE.
REQ-026 No rc_done SHALL be produced for an operation interrupted by reset.
REQ-027 After reset release, rc_cmd=1 SHALL be accepted at the first edge with rst_n=1.

Verification
REQ-028 MUL op1=7, op2=6, rc_cmd held until done -> rc_done single pulse DATA_W+1 cycles after accept, rc_result=0x0000002A, rc_busy high from accept until RELEASE exits.
REQ-029 op1=op2=0xFFFFFFFF: MUL -> 0x00000001; MULHU -> 0xFFFFFFFE.
REQ-030 POPC op1=0xF0F0F0F0 -> 0x00000010; POPC op1=0xFFFFFFFF -> 0x00000020; rc_fun=11 -> 0x00000000 with the same latency.
REQ-031 rc_cmd dropped at RUN iteration 10 -> no rc_done, rc_result unchanged, state IDLE on the next edge; rc_cmd held high through RELEASE -> no second operation.
REQ-032 rst_n=0 at RUN iteration 20 -> all outputs 0 next cycle, no done; new MUL 3*5 after reset -> 0x0000000F.
REQ-033 Back-to-back: rc_cmd dropped one cycle after done, then 9*9 requested -> accepted at the next edge, rc_result=0x00000051; operands changed mid-RUN -> result unaffected.
